// File: rtl/collision_edge_detector.sv
// Per-frame collision accumulator for the player sprite: counts overlap pixels
// in total and per edge band, and publishes thresholded flags at each startOfFrame.
module collision_edge_detector #(
  parameter int OBJ_W         = 32,
  parameter int OBJ_H         = 32,
  parameter int EDGE          = 4,
  parameter int HIT_THRESHOLD = 2,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic        smileyDR,
  input  logic        brickDR,
  output logic        collision,
  output logic [3:0]  HitEdgeCode,
  output logic        fsm_state_o
);

  typedef enum logic {
    ACCUM   = 1'b0,
    PUBLISH = 1'b1
  } state_t;

  localparam logic signed [12:0] OBJ_W_S   = 13'(OBJ_W);
  localparam logic signed [12:0] OBJ_H_S   = 13'(OBJ_H);
  localparam logic signed [12:0] EDGE_S    = 13'(EDGE);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   CNT_ZERO  = '0;

  state_t state_q, state_d;

  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic [CNT_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] right_q, right_d;
  logic [CNT_W-1:0] bottom_q, bottom_d;

  logic       collision_q, collision_d;
  logic [3:0] edge_q, edge_d;

  // 13 bits so pixel (0..2047) minus a signed origin (-1024..1023) never overflows.
  logic signed [12:0] off_x;
  logic signed [12:0] off_y;
  logic overlap;
  logic in_box;
  logic hit_left, hit_top, hit_right, hit_bottom;

  assign off_x = $signed({2'b00, pixelX}) - $signed({{2{topLeftX[10]}}, topLeftX});
  assign off_y = $signed({2'b00, pixelY}) - $signed({{2{topLeftY[10]}}, topLeftY});

  assign overlap    = smileyDR & brickDR;
  assign in_box     = overlap &&
                      (off_x >= 13'sd0) && (off_x < OBJ_W_S) &&
                      (off_y >= 13'sd0) && (off_y < OBJ_H_S);
  assign hit_left   = in_box && (off_x < EDGE_S);
  assign hit_right  = in_box && (off_x >= (OBJ_W_S - EDGE_S));
  assign hit_top    = in_box && (off_y < EDGE_S);
  assign hit_bottom = in_box && (off_y >= (OBJ_H_S - EDGE_S));

  // At startOfFrame the count restarts from this cycle's own contribution.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] cur,
                                                input logic             inc,
                                                input logic             sof);
    logic [CNT_W-1:0] base;
    base = sof ? CNT_ZERO : cur;
    if (inc && (base != CNT_MAX)) begin
      return base + 1'b1;
    end
    return base;
  endfunction

  always_comb begin
    total_d  = next_cnt(total_q,  overlap,    startOfFrame);
    left_d   = next_cnt(left_q,   hit_left,   startOfFrame);
    top_d    = next_cnt(top_q,    hit_top,    startOfFrame);
    right_d  = next_cnt(right_q,  hit_right,  startOfFrame);
    bottom_d = next_cnt(bottom_q, hit_bottom, startOfFrame);
  end

  always_comb begin
    state_d     = state_q;
    collision_d = collision_q;
    edge_d      = edge_q;
    if (startOfFrame) begin
      collision_d = (32'(total_q)  >= HIT_THRESHOLD);
      edge_d[3]   = (32'(left_q)   >= HIT_THRESHOLD);
      edge_d[2]   = (32'(top_q)    >= HIT_THRESHOLD);
      edge_d[1]   = (32'(right_q)  >= HIT_THRESHOLD);
      edge_d[0]   = (32'(bottom_q) >= HIT_THRESHOLD);
    end
    case (state_q)
      ACCUM:   if (startOfFrame) state_d = PUBLISH;
      PUBLISH: state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ACCUM;
      total_q     <= '0;
      left_q      <= '0;
      top_q       <= '0;
      right_q     <= '0;
      bottom_q    <= '0;
      collision_q <= 1'b0;
      edge_q      <= 4'b0000;
    end else begin
      state_q     <= state_d;
      total_q     <= total_d;
      left_q      <= left_d;
      top_q       <= top_d;
      right_q     <= right_d;
      bottom_q    <= bottom_d;
      collision_q <= collision_d;
      edge_q      <= edge_d;
    end
  end

  assign collision   = collision_q;
  assign HitEdgeCode = edge_q;
  assign fsm_state_o = state_q;

endmodule

// File: doc/collision_edge_detector.md
COLLISION_EDGE_DETECTOR -- requirements
Module: collision_edge_detector

Interface
REQ-001 SHALL have parameter OBJ_W, default 32, meaning player sprite width in pixels.
REQ-002 SHALL have parameter OBJ_H, default 32, meaning player sprite height in pixels.
REQ-003 SHALL have parameter EDGE, default 4, meaning depth in pixels of each edge band inside the sprite box.
REQ-004 SHALL have parameter HIT_THRESHOLD, default 2, meaning the minimum overlap pixels per frame to report a hit.
REQ-005 SHALL have parameter CNT_W, default 8, meaning the width of each saturating counter.
REQ-006 SHALL have port clk  input  1  system clock.
REQ-007 SHALL have port resetN  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port startOfFrame  input  1  one-cycle pulse at the start of each video frame.
REQ-009 SHALL have port pixelX  input  11  current scan pixel X, unsigned.
REQ-010 SHALL have port pixelY  input  11  current scan pixel Y, unsigned.
REQ-011 SHALL have port topLeftX  input  11  player sprite top-left X, signed.
REQ-012 SHALL have port topLeftY  input  11  player sprite top-left Y, signed.
REQ-013 SHALL have port smileyDR  input  1  player drawing request for the current pixel.
REQ-014 SHALL have port brickDR  input  1  brick/platform drawing request for the current pixel.
REQ-015 SHALL have port collision  output  1  registered; previous frame had at least HIT_THRESHOLD overlap pixels.
REQ-016 SHALL have port HitEdgeCode  output  4  registered per-edge hit flags of the player box: [3] left, [2] top, [1] right, [0] bottom.

Function
REQ-017 SHALL define an overlap pixel as a cycle with smileyDR=1 and brickDR=1.
REQ-018 SHALL compute offX = pixelX - topLeftX and offY = pixelY - topLeftY as signed values at least 12 bits wide.
REQ-019 SHALL classify an overlap as in-box only when 0<=offX<OBJ_W and 0<=offY<OBJ_H.
REQ-020 SHALL classify edges for an in-box overlap as: left if offX<EDGE; right if offX>=OBJ_W-EDGE; top if offY<EDGE; bottom if offY>=OBJ_H-EDGE.
REQ-021 SHALL allow one overlap to increment several edge counters (corners), and SHALL let it increment none (interior).
REQ-022 SHALL hold five CNT_W-bit counters: total, left, top, right, bottom.
REQ-023 SHALL increment total on every overlap pixel, including out-of-box overlaps, and SHALL increment each edge counter only on a classified edge hit.
REQ-024 SHALL saturate every counter at 2^CNT_W-1 and never wrap.
REQ-025 SHALL use a two-state FSM, ACCUM and PUBLISH; reset enters ACCUM.
REQ-026 SHALL go from ACCUM to PUBLISH on a cycle with startOfFrame=1, and from PUBLISH to ACCUM unconditionally on the next cycle.
REQ-027 SHALL, on the clock edge where startOfFrame=1, load collision <= (total>=HIT_THRESHOLD) and load each HitEdgeCode bit <= (its edge counter>=HIT_THRESHOLD).
REQ-028 SHALL make the published outputs visible one cycle after the startOfFrame cycle, and SHALL hold them constant until the next startOfFrame.
REQ-029 SHALL, on that same edge, load each counter with that cycle's own contribution (0 or 1), so an overlap coincident with startOfFrame counts toward the new frame.
REQ-030 SHALL accumulate normally in PUBLISH; PUBLISH only asserts that the outputs were refreshed, and no overlap is dropped.
REQ-031 SHALL never let more than one publish happen per startOfFrame pulse; back-to-back startOfFrame cycles each publish, and the second publish uses counts holding at most 1.
REQ-032 SHALL ignore smileyDR or brickDR alone.

Reset
REQ-033 SHALL, while resetN=0, force collision=0, HitEdgeCode=4'b0000, all counters=0 and FSM=ACCUM.
REQ-034 SHALL discard any partial frame when reset is asserted mid-frame; the next publish reflects only post-reset overlaps.

Verification
REQ-035 SHALL be verified with: topLeft=(100,200), 2 overlaps at pixel (110,230), then startOfFrame -> next cycle collision=1, HitEdgeCode=4'b0001.
REQ-036 SHALL be verified with: 1 overlap at (110,230) only, then startOfFrame -> collision=0, HitEdgeCode=4'b0000.
REQ-037 SHALL be verified with: 3 overlaps at (101,201), then startOfFrame -> collision=1, HitEdgeCode=4'b1100; a following frame with no overlaps -> all outputs 0 after its startOfFrame.
REQ-038 SHALL be verified with: 300 overlaps at (131,231), then startOfFrame -> collision=1, HitEdgeCode=4'b0011, and internal counters hold 255 before the publish.
REQ-039 SHALL be verified with: 1 overlap at (110,230) coincident with startOfFrame, plus 1 more after it, then the next startOfFrame -> collision=1, HitEdgeCode=4'b0001.
REQ-040 SHALL be verified with: 5 overlaps, resetN pulsed low mid-frame, no further overlaps, then startOfFrame -> collision=0, HitEdgeCode=4'b0000.
